req_capture: RTL and testbench

Request capture and service stage that sits directly upstream of the 12-to-4 priority encoder. It converts 12 raw level request lines into sticky pending bits and drives them onto the encoder's 12-bit input. It then takes the encoder's 4-bit code back, presents it to a consumer as a held grant with a valid/ack handshake, and clears the serviced pending bit on acknowledge.

---
 rtl/req_capture_if.sv | 35 +++
 rtl/req_capture.sv | 97 +++++++++
 tb/tb_req_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/req_capture_if.sv
// Request capture bus: raw requests in, sticky pending vector out to the
// priority encoder, encoder code back in, and the grant handshake to the consumer.
//   req_in      : raw request levels (synchronous to clk)
//   pend        : sticky pending vector, drives encoder input
//   code_in     : encoder output code (0 = none, k = channel k-1)
//   grant_valid : grant presented
//   grant_code  : granted code, stable while grant_valid
//   grant_ack   : consumer accepts the grant
//   overrun     : per-channel sticky overrun flags
//   overrun_clr : clears all overrun flags
interface req_capture_if;
  localparam int unsigned N  = 12;
  localparam int unsigned CW = 4;

  logic [N-1:0]  req_in;
  logic [N-1:0]  pend;
  logic [CW-1:0] code_in;
  logic          grant_valid;
  logic [CW-1:0] grant_code;
  logic          grant_ack;
  logic [N-1:0]  overrun;
  logic          overrun_clr;

  // Environment side: drives requests, encoder code and consumer handshake.
  modport master (
    output req_in, code_in, grant_ack, overrun_clr,
    input  pend, grant_valid, grant_code, overrun
  );

  // Capture stage side.
  modport slave (
    input  req_in, code_in, grant_ack, overrun_clr,
    output pend, grant_valid, grant_code, overrun
  );
endinterface

// File: rtl/req_capture.sv
// Request capture and service stage upstream of a 12-to-4 priority encoder.
// Rising request edges become sticky pending bits; the encoder's code is
// latched into a held grant, and the serviced pending bit clears on ack.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : req_capture_if.slave (requests, pending, code, grant handshake, overrun)
module req_capture (
  input logic           clk,
  input logic           reset,
  req_capture_if.slave  bus
);
  localparam int unsigned N  = 12;
  localparam int unsigned CW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  prev;
  logic [N-1:0]  pend;
  logic [N-1:0]  overrun;
  logic          grant_valid;
  logic [CW-1:0] grant_code;

  logic [N-1:0]  rise;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  ovr_set;
  logic          code_ok;
  logic          ack_fire;

  assign rise     = bus.req_in & ~prev;
  assign ack_fire = grant_valid & bus.grant_ack;
  // Codes 0 and 13..15 mean no request.
  assign code_ok  = (bus.code_in != '0) && (bus.code_in <= CW'(N));

  // One-hot clear of the serviced channel on acknowledge.
  always_comb begin
    clr_mask = '0;
    if (ack_fire && grant_code != '0) begin
      clr_mask = N'(1) << (grant_code - CW'(1));
    end
  end

  // A repeat edge on an already-pending bit is an overrun unless that bit is
  // being serviced this cycle (then the edge simply re-arms it).
  assign ovr_set = rise & pend & ~clr_mask;

  // Edge detect, pending and overrun tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      pend    <= '0;
      overrun <= '0;
    end else begin
      prev    <= bus.req_in;
      pend    <= (pend & ~clr_mask) | rise;
      overrun <= bus.overrun_clr ? ovr_set : (overrun | ovr_set);
    end
  end

  // Grant FSM: latch the encoder code, hold it until acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (code_ok) begin
            grant_code  <= bus.code_in;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (bus.grant_ack) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.pend        = pend;
  assign bus.overrun     = overrun;
  assign bus.grant_valid = grant_valid;
  assign bus.grant_code  = grant_code;

endmodule

// File: tb/tb_req_capture.sv
// Scoreboard bench for req_capture with a behavioural 12-to-4 priority encoder.
module tb_req_capture;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  req_capture_if bus ();

  req_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Priority encoder: highest pending channel wins, code = index + 1.
  logic [3:0] enc;
  always_comb begin
    enc = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (bus.pend[i]) enc = 4'(i + 1);
    end
  end
  assign bus.code_in = enc;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  logic       last_valid = 1'b0;
  logic [3:0] held_code  = 4'd0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each new grant pops the next expected code; held grants must not change.
  always @(negedge clk) begin
    if (bus.grant_valid && !last_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_grant: got code %0d expected none at %0t", bus.grant_code, $time);
      end else begin
        check("grant_code", int'(bus.grant_code), exp_q.pop_front());
      end
      held_code = bus.grant_code;
    end else if (bus.grant_valid) begin
      check("grant_hold", int'(bus.grant_code), int'(held_code));
    end
    last_valid = bus.grant_valid;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (!bus.grant_valid && k < 20) begin
      tick();
      k++;
    end
    if (!bus.grant_valid) begin
      n_total++;
      $display("FAIL grant_timeout: got no grant expected grant within 20 cycles at %0t", $time);
    end
  endtask

  // Ack the current grant; optionally require the next grant after exactly one low cycle.
  task automatic ack_grant(input bit more);
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    check("gap_low", int'(bus.grant_valid), 0);
    if (more) begin
      tick();
      check("next_grant", int'(bus.grant_valid), 1);
    end
  endtask

  task automatic pulse_req(input logic [11:0] v);
    bus.req_in = v;
    tick();
    bus.req_in = 12'h000;
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_in      = 12'h000;
    bus.grant_ack   = 1'b0;
    bus.overrun_clr = 1'b0;
    tick(2);
    check("rst_pend", int'(bus.pend), 0);
    check("rst_valid", int'(bus.grant_valid), 0);
    check("rst_code", int'(bus.grant_code), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    tick();

    // Single request on channel 4.
    exp_q.push_back(5);
    pulse_req(12'h010);
    check("single_pend", int'(bus.pend), 12'h010);
    check("single_valid_early", int'(bus.grant_valid), 0);
    tick();
    check("single_valid", int'(bus.grant_valid), 1);
    ack_grant(1'b0);
    check("single_pend_clr", int'(bus.pend), 0);

    // Priority order 12, 8, 1.
    tick(2);
    exp_q.push_back(12);
    exp_q.push_back(8);
    exp_q.push_back(1);
    pulse_req(12'h881);
    check("prio_pend", int'(bus.pend), 12'h881);
    wait_grant();
    ack_grant(1'b1);
    ack_grant(1'b1);
    ack_grant(1'b0);
    check("prio_pend_end", int'(bus.pend), 0);

    // No preemption: grant 3 held while channel 10 arrives.
    tick(2);
    exp_q.push_back(3);
    pulse_req(12'h004);
    wait_grant();
    exp_q.push_back(11);
    pulse_req(12'h400);
    tick(2);
    check("nopre_code", int'(bus.grant_code), 3);
    check("nopre_pend", int'(bus.pend), 12'h404);
    ack_grant(1'b1);
    ack_grant(1'b0);
    check("nopre_pend_end", int'(bus.pend), 0);

    // Overrun on channel 2 while grant 1 is held.
    tick(2);
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse_req(12'h001);
    wait_grant();
    bus.req_in = 12'h004;
    tick();
    bus.req_in = 12'h000;
    tick();
    bus.req_in = 12'h004;
    tick();
    bus.req_in = 12'h000;
    check("ovr_flag", int'(bus.overrun), 12'h004);
    check("ovr_pend", int'(bus.pend), 12'h005);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    check("ovr_clr", int'(bus.overrun), 0);
    ack_grant(1'b1);
    ack_grant(1'b0);
    check("ovr_pend_end", int'(bus.pend), 0);

    // Set/clear collision on channel 5.
    tick(2);
    exp_q.push_back(6);
    pulse_req(12'h020);
    wait_grant();
    exp_q.push_back(6);
    bus.req_in    = 12'h020;
    bus.grant_ack = 1'b1;
    tick();
    bus.req_in    = 12'h000;
    bus.grant_ack = 1'b0;
    check("coll_pend", int'(bus.pend), 12'h020);
    check("coll_overrun", int'(bus.overrun), 0);
    check("coll_gap", int'(bus.grant_valid), 0);
    tick();
    check("coll_regrant", int'(bus.grant_valid), 1);
    ack_grant(1'b0);
    check("coll_pend_end", int'(bus.pend), 0);

    // Held line through reset, then reset mid-grant.
    tick(2);
    reset      = 1'b1;
    bus.req_in = 12'hFFF;
    tick(2);
    reset = 1'b0;
    exp_q.push_back(12);
    tick();
    check("held_pend", int'(bus.pend), 12'hFFF);
    tick();
    check("held_valid", int'(bus.grant_valid), 1);
    reset = 1'b1;
    tick();
    check("midrst_valid", int'(bus.grant_valid), 0);
    check("midrst_code", int'(bus.grant_code), 0);
    check("midrst_pend", int'(bus.pend), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    exp_q.push_back(12);
    tick();
    check("rel_pend", int'(bus.pend), 12'hFFF);
    tick();
    check("rel_valid", int'(bus.grant_valid), 1);
    tick();
    reset      = 1'b1;
    bus.req_in = 12'h000;
    tick(2);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
